// File: rtl/bcm_plane_scheduler.sv
// Binary-coded-modulation plane sequencer for one panel row: drives the pixel shifter
// and one shared timeout so that each bitplane is displayed for base_period << plane clocks.
module bcm_plane_scheduler #(
  parameter int PLANES        = 6,
  parameter int PLANE_WIDTH   = 3,
  parameter int BASE_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     abort,
  input  logic [BASE_WIDTH-1:0]    base_period,
  input  logic                     plane_ready,
  input  logic                     timer_running,
  output logic [PLANE_WIDTH-1:0]   plane_index,
  output logic                     plane_request,
  output logic                     timer_start,
  output logic [COUNTER_WIDTH-1:0] timer_value,
  output logic                     output_enable,
  output logic                     busy,
  output logic                     done
);

  localparam int WIDE_WIDTH = COUNTER_WIDTH + PLANES;
  localparam logic [PLANE_WIDTH-1:0] LAST_PLANE = PLANE_WIDTH'(PLANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    ARM,
    DISPLAY,
    NEXT,
    DONE
  } state_t;

  state_t                  state;
  logic [BASE_WIDTH-1:0]   base_q;
  logic [WIDE_WIDTH-1:0]   shifted;
  logic [COUNTER_WIDTH-1:0] arm_value;

  // The shift is done wide enough that no bit is lost, then clamped to the timer width.
  assign shifted   = WIDE_WIDTH'(base_q) << plane_index;
  assign arm_value = (|shifted[WIDE_WIDTH-1:COUNTER_WIDTH]) ? {COUNTER_WIDTH{1'b1}}
                                                            : shifted[COUNTER_WIDTH-1:0];

  // Gating by state makes OE drop at once on abort or reset, even while the timeout still runs.
  assign output_enable = timer_running && (state == DISPLAY);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      plane_index   <= '0;
      plane_request <= 1'b0;
      timer_start   <= 1'b0;
      timer_value   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      timer_start <= 1'b0;
      done        <= 1'b0;
      if (abort && (state != IDLE)) begin
        state         <= IDLE;
        plane_request <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              base_q        <= base_period;
              plane_index   <= '0;
              plane_request <= 1'b1;
              busy          <= 1'b1;
              state         <= REQUEST;
            end
          end
          REQUEST: begin
            if (plane_ready) begin
              plane_request <= 1'b0;
              timer_start   <= 1'b1;
              timer_value   <= arm_value;
              state         <= ARM;
            end
          end
          ARM: state <= DISPLAY;
          DISPLAY: begin
            if (!timer_running) state <= NEXT;
          end
          NEXT: begin
            if (plane_index == LAST_PLANE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              plane_index   <= plane_index + PLANE_WIDTH'(1);
              plane_request <= 1'b1;
              state         <= REQUEST;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
